// File: rtl/painel_scan_ctrl.sv
// painel_scan_ctrl - column scan sequencer for a 7-column LED panel.
//
// Each column slot lasts DIV clocks: BLANK blanked cycles (col_en = 0,
// row select already pointing at the new column), then DIV-BLANK drive
// cycles with exactly one column enable active. Columns run 0..6 and wrap.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   enable       scan enable; low returns to IDLE on the next clock
//   sel1..sel3   row-bit select (sel1 = MSB), equals the current column index
//   col_en[6:0]  one-hot column enables, col_en[6] = column 0
//   addr[3:0]    message column address for the pattern memory
//   frame_start  one-cycle pulse in the first blank cycle of column 0
//
// Optional feature: define PAINEL_SCROLL_EN to add horizontal scrolling.
// The message offset advances by one column every SCROLL_FRAMES completed
// frames and wraps at MSG_LEN. Without the macro, addr is the column index
// and MSG_LEN / SCROLL_FRAMES only take part in the parameter range check.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | scan stopped, all outputs quiet, column index 0
// ST_BLANK | start of a column slot, drivers off, selects settling
// ST_DRIVE | current column driven for the rest of the slot

module painel_scan_ctrl #(
  parameter int DIV           = 1000,
  parameter int BLANK         = 8,
  parameter int MSG_LEN       = 16,
  parameter int SCROLL_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic [6:0] col_en,
  output logic [3:0] addr,
  output logic       frame_start
);

  generate
    if (DIV < 4 || DIV > 65535 || BLANK < 1 || BLANK > DIV - 2 ||
        MSG_LEN < 7 || MSG_LEN > 16 ||
        SCROLL_FRAMES < 1 || SCROLL_FRAMES > 255) begin : g_bad_param
      $error("painel_scan_ctrl: parameter out of legal range");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

  // Down-counter reload values; a phase ends on the cycle the counter is 0.
  localparam logic [15:0] BLANK_LD = 16'(BLANK - 1);
  localparam logic [15:0] DRIVE_LD = 16'(DIV - BLANK - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  col;
  logic [2:0]  col_nxt;
  logic [3:0]  addr_nxt;   // address for the column about to be blanked
  logic [3:0]  addr_idle;  // address parked while the scan is stopped
  logic        slot_end;

  assign col_nxt  = (col == 3'd6) ? 3'd0 : col + 3'd1;
  assign slot_end = (state == ST_DRIVE) && (cnt == '0);

  // col only moves on BLANK entry, so it doubles as the registered select.
  assign {sel1, sel2, sel3} = col;

`ifdef PAINEL_SCROLL_EN
  logic [7:0] frame_cnt;
  logic [3:0] offset;
  logic [3:0] offset_nxt;
  logic       step;

  function automatic logic [3:0] wrap_add(input logic [2:0] c, input logic [3:0] o);
    logic [4:0] s;
    s = {2'b00, c} + {1'b0, o};
    // c <= 6 and o < MSG_LEN, so one subtraction is enough.
    if (s >= 5'(MSG_LEN)) s = s - 5'(MSG_LEN);
    return 4'(s);
  endfunction

  // The step lands on the 6->0 wrap, so column 0 of the new frame is the
  // first to see the new offset and no frame mixes two offsets.
  assign step       = slot_end && (col == 3'd6) && (frame_cnt == 8'(SCROLL_FRAMES - 1));
  assign offset_nxt = step ? ((offset == 4'(MSG_LEN - 1)) ? 4'd0 : offset + 4'd1) : offset;
  assign addr_nxt   = wrap_add(col_nxt, offset_nxt);
  assign addr_idle  = wrap_add(3'd0, offset);

  // Gated by enable: a frame boundary coinciding with enable falling is
  // not counted and its scroll step is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      offset    <= '0;
    end else if (enable && slot_end && (col == 3'd6)) begin
      offset    <= offset_nxt;
      frame_cnt <= step ? 8'd0 : frame_cnt + 8'd1;
    end
  end
`else
  assign addr_nxt  = {1'b0, col_nxt};
  assign addr_idle = 4'd0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      col         <= '0;
      col_en      <= '0;
      addr        <= '0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      col         <= '0;
      col_en      <= '0;
      addr        <= addr_idle;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          state       <= ST_BLANK;
          cnt         <= BLANK_LD;
          col         <= '0;
          col_en      <= '0;
          addr        <= addr_idle;
          frame_start <= 1'b1;
        end
        ST_BLANK: begin
          if (cnt == '0) begin
            state  <= ST_DRIVE;
            cnt    <= DRIVE_LD;
            col_en <= 7'b100_0000 >> col;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_DRIVE: begin
          if (cnt == '0) begin
            state       <= ST_BLANK;
            cnt         <= BLANK_LD;
            col_en      <= '0;
            col         <= col_nxt;
            addr        <= addr_nxt;
            frame_start <= (col == 3'd6);
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/painel_scan_ctrl.md
PAINEL_SCAN_CTRL -- requirements
Module: painel_scan_ctrl

Interface
REQ-001 The block SHALL have a parameter DIV, default 1000, giving clock cycles per column slot (legal range 4..65535).
REQ-002 The block SHALL have a parameter BLANK, default 8, giving blanked cycles at the start of each slot (legal range 1..DIV-2).
REQ-003 The block SHALL have a parameter MSG_LEN, default 16, giving message length in columns (legal range 7..16).
REQ-004 The block SHALL have a parameter SCROLL_FRAMES, default 30, giving frames per scroll step (legal range 1..255).
REQ-005 Port clk, input, 1 bit: single system clock, rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port enable, input, 1 bit: scan enable, active high.
REQ-008 Ports sel1, sel2, sel3, output, 1 bit each: 3-bit row-bit select to the downstream row multiplexer; sel1 is MSB; values 000..110 select linha[6]..linha[0].
REQ-009 Port col_en, output, 7 bits: one-hot column driver enables; col_en[6] drives column 0 and col_en[0] drives column 6.
REQ-010 Port addr, output, 4 bits: message column address for the pattern memory.
REQ-011 Port frame_start, output, 1 bit: one-cycle pulse at the start of column 0.

Function
REQ-012 States SHALL be IDLE, BLANK and DRIVE.
REQ-013 In IDLE, col_en SHALL be 0, the column index SHALL be 0, and {sel1,sel2,sel3} SHALL be 000.
REQ-014 IDLE->BLANK SHALL occur on the first clock with enable=1; frame_start SHALL pulse in that same first BLANK cycle.
REQ-015 The state SHALL remain BLANK for exactly BLANK cycles with col_en=0 and sel equal to the current column index.
REQ-016 BLANK->DRIVE SHALL then occur; DRIVE SHALL last DIV-BLANK cycles with col_en one-hot for the current column.
REQ-017 At the end of DRIVE, the column index SHALL increment 0..6 and wrap 6->0, and the state SHALL return to BLANK.
REQ-018 frame_start SHALL pulse in the first BLANK cycle of every column 0.
REQ-019 sel and addr SHALL change only on BLANK entry, never during DRIVE; sel SHALL never take 111.
REQ-020 A column SHALL occupy exactly DIV cycles, and a frame SHALL occupy exactly 7*DIV cycles.
REQ-021 If enable falls in any state, the next clock SHALL enter IDLE, col_en SHALL be 0 from that edge, and the column SHALL restart at 0 on re-enable.
REQ-022 All outputs SHALL be registered, with no combinational path from enable to any output.

Reset
REQ-023 reset_n=0 SHALL force IDLE immediately and asynchronously.
REQ-024 Under reset: col_en=0, sel=000, addr=0, frame_start=0, and all counters (cycle, column, frame, scroll) =0.
REQ-025 Reset asserted mid-DRIVE SHALL clear col_en without waiting for a clock edge.
REQ-026 Release SHALL be sampled synchronously, and the first state change SHALL occur on the first edge after release with enable=1.

Configuration
REQ-027 Macro PAINEL_SCROLL_EN SHALL control scrolling.
REQ-028 With PAINEL_SCROLL_EN defined, a frame counter SHALL count completed frames; every SCROLL_FRAMES frames, the scroll offset SHALL increment at the frame boundary, wrapping at MSG_LEN-1->0.
REQ-029 With PAINEL_SCROLL_EN defined, addr SHALL equal (column + offset) mod MSG_LEN.
REQ-030 A scroll step coinciding with the column 6->0 wrap SHALL apply to column 0 of the new frame, with no torn frame.
REQ-031 A scroll step coinciding with enable falling SHALL be discarded.
REQ-032 Without PAINEL_SCROLL_EN, no frame or offset registers SHALL exist, addr SHALL equal the zero-extended column index, and SCROLL_FRAMES and MSG_LEN SHALL be unused.

Verification
REQ-033 Reset, then enable=1 with DIV=10, BLANK=2: frame_start pulses at cycle 1; col_en=0 for 2 cycles, then 1000000 for 8 cycles, then sel=001, and so on.
REQ-034 Run 3 frames: col_en never has more than one bit set; sel sequence 000..110 repeats; frame_start period=70 cycles.
REQ-035 Drop enable in DRIVE of column 4, then re-enable: col_en=0 next cycle; scan restarts at column 0 with frame_start.
REQ-036 Assert reset_n=0 mid-DRIVE between clock edges: col_en=0 immediately, all outputs at reset values.
REQ-037 PAINEL_SCROLL_EN with SCROLL_FRAMES=2, MSG_LEN=8: column 0 addr sequence across frames is 0,0,1,1,...,7,7,0; column 6 at offset 3 gives addr=1.
REQ-038 PAINEL_SCROLL_EN undefined: addr equals column index 0..6 in every frame, and a 20-frame run shows no addr change beyond that.
